// File: rtl/jtag_dmi_pkg.sv
// Shared instruction codes, DMI encodings and DTMCS layout for the JTAG DTM data-register chain.
package jtag_dmi_pkg;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSV   = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_RSV    = 2'd1,
    ST_FAILED = 2'd2,
    ST_BUSY   = 2'd3
  } dmi_status_e;

  typedef struct packed {
    logic [13:0] zero;
    logic        dmihardreset;
    logic        dmireset;
    logic        rsv;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/jtag_dmi_req_fsm.sv
// DMI request/response handshake FSM: holds the request payload and drops responses
// belonging to a transfer that was abandoned by dmihardreset or TAP reset.
module jtag_dmi_req_fsm
  import jtag_dmi_pkg::*;
#(
  parameter int unsigned ABITS = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [ABITS-1:0] addr_i,
  input  logic [31:0]      data_i,
  input  logic [1:0]       op_i,
  input  logic             discard_set_i,
  output logic             busy_o,
  output logic             resp_done_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [ABITS-1:0] req_addr_o,
  output logic [31:0]      req_data_o,
  output logic [1:0]       req_op_o,
  input  logic             resp_valid_i,
  output logic             resp_ready_o
);

  fsm_state_e       state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic             discard_q, discard_d;
  logic             discard_now;

  // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      discard_q <= discard_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    op_d        = op_q;
    discard_d   = discard_q;
    resp_done_o = 1'b0;
    // A discard request in the completing cycle still drops that response.
    discard_now = discard_q | (discard_set_i & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = addr_i;
          data_d  = data_i;
          op_d    = op_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        discard_d = discard_now;
        if (req_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        discard_d = discard_now;
        if (resp_valid_i) begin
          state_d     = S_IDLE;
          resp_done_o = ~discard_now;
          discard_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign req_valid_o  = (state_q == S_REQ);
  assign resp_ready_o = (state_q == S_RESP);
  assign req_addr_o   = addr_q;
  assign req_data_o   = data_q;
  assign req_op_o     = op_q;

endmodule

// File: rtl/jtag_dmi_chain.sv
// JTAG DTM data-register back end: shared DR shift register, DTMCS/DMI/BYPASS decode and sticky status.
// Define JTAG_DMI_IDCODE_EN to make instruction 0x01 select the 32-bit IDCODE register instead of BYPASS.
module jtag_dmi_chain
  import jtag_dmi_pkg::*;
#(
  parameter int unsigned ABITS    = 7,
  parameter logic [31:0] IDCODE   = 32'h0000_0001,
  parameter logic [2:0]  DTM_IDLE = 3'd1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       instruction,
  input  logic             tap_reset,
  input  logic             dr_shift,
  input  logic             dr_capture,
  input  logic             dr_update,
  input  logic             dr_data,
  output logic             dr_tdo,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_resp_valid,
  output logic             dmi_resp_ready,
  input  logic [31:0]      dmi_resp_data,
  input  logic [1:0]       dmi_resp_resp
);

  localparam int unsigned W = ABITS + 34;

  logic [W-1:0]     sr_q, sr_d;
  logic             upd_q;
  dmi_status_e      sticky_q, sticky_d;
  logic [31:0]      result_q, result_d;
  logic [ABITS-1:0] last_addr_q, last_addr_d;

  logic             fsm_busy, resp_done, req_start, discard_set;
  logic             upd_fire, sel_dmi, sel_dtmcs;
  logic [ABITS-1:0] sr_addr;
  logic [31:0]      sr_data;
  dmi_op_e          sr_op;
  dmi_status_e      cap_status;
  dtmcs_t           dtmcs;

  assign upd_fire  = dr_update & ~upd_q;
  assign sel_dmi   = (instruction == IR_DMI);
  assign sel_dtmcs = (instruction == IR_DTMCS);
  assign sr_addr   = sr_q[W-1:34];
  assign sr_data   = sr_q[33:2];
  assign sr_op     = dmi_op_e'(sr_q[1:0]);
  assign cap_status = fsm_busy ? ST_BUSY : sticky_q;
  assign dr_tdo    = sr_q[0];

  assign req_start = upd_fire & sel_dmi & ~tap_reset & ~fsm_busy & (sticky_q == ST_OK) &
                     ((sr_op == OP_READ) || (sr_op == OP_WRITE));
  assign discard_set = tap_reset | (upd_fire & sel_dtmcs & sr_q[17]);

  always_comb begin
    dtmcs         = '0;
    dtmcs.idle    = DTM_IDLE;
    dtmcs.dmistat = sticky_q;
    dtmcs.abits   = 6'(ABITS);
    dtmcs.version = 4'd1;
  end

  always_comb begin
    sr_d = sr_q;
    if (tap_reset) begin
      sr_d = '0;
    end else if (dr_capture) begin
      case (instruction)
        IR_DMI:    sr_d = {last_addr_q, result_q, cap_status};
        IR_DTMCS:  sr_d = W'(dtmcs);
`ifdef JTAG_DMI_IDCODE_EN
        IR_IDCODE: sr_d = W'(IDCODE);
`endif
        default:   sr_d = '0;
      endcase
    end else if (dr_shift) begin
      // TDI enters at the top bit of whichever register is selected.
      sr_d = sr_q >> 1;
      case (instruction)
        IR_DMI:    sr_d[W-1] = dr_data;
        IR_DTMCS:  sr_d[31]  = dr_data;
`ifdef JTAG_DMI_IDCODE_EN
        IR_IDCODE: sr_d[31]  = dr_data;
`endif
        default:   sr_d[0]   = dr_data;
      endcase
    end
  end

  // Later assignments win: failed < busy < dmireset/dmihardreset < tap_reset.
  always_comb begin
    sticky_d    = sticky_q;
    result_d    = result_q;
    last_addr_d = last_addr_q;
    if (resp_done) begin
      result_d = dmi_resp_data;
      if ((dmi_resp_resp != 2'd0) && (sticky_q != ST_BUSY)) sticky_d = ST_FAILED;
    end
    if (upd_fire && sel_dmi && fsm_busy) sticky_d = ST_BUSY;
    if (upd_fire && sel_dtmcs && (sr_q[16] || sr_q[17])) sticky_d = ST_OK;
    if (req_start) last_addr_d = sr_addr;
    if (tap_reset) begin
      sticky_d    = ST_OK;
      result_d    = '0;
      last_addr_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q        <= '0;
      upd_q       <= 1'b0;
      sticky_q    <= ST_OK;
      result_q    <= '0;
      last_addr_q <= '0;
    end else begin
      sr_q        <= sr_d;
      upd_q       <= dr_update;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      last_addr_q <= last_addr_d;
    end
  end

  jtag_dmi_req_fsm #(.ABITS(ABITS)) u_req_fsm (
    .clock         (clock),
    .reset         (reset),
    .start_i       (req_start),
    .addr_i        (sr_addr),
    .data_i        (sr_data),
    .op_i          (sr_q[1:0]),
    .discard_set_i (discard_set),
    .busy_o        (fsm_busy),
    .resp_done_o   (resp_done),
    .req_valid_o   (dmi_req_valid),
    .req_ready_i   (dmi_req_ready),
    .req_addr_o    (dmi_req_addr),
    .req_data_o    (dmi_req_data),
    .req_op_o      (dmi_req_op),
    .resp_valid_i  (dmi_resp_valid),
    .resp_ready_o  (dmi_resp_ready)
  );

endmodule

// File: doc/jtag_dmi_chain.md
Name: jtag_dmi_chain

Overview:
- Data-register back end of the JTAG TAP, clocked on the TAP's TCK.
- Consumes the TAP's instruction, reset, shift, capture, update and data-out signals.
- Returns the serial TDO bit to the TAP.
- Implements the DTMCS (0x10), DMI (0x11) and IDCODE/BYPASS (0x01) data registers, plus a 1-bit BYPASS register for all other instructions.
- Issues DMI read/write requests to the debug module over a valid/ready handshake.

Parameters:
- ABITS, 7: DMI address width, legal range 1..30.
- IDCODE, 32'h0000_0001: value captured by the IDCODE register; bit 0 must be 1.
- DTM_IDLE, 3'd1: idle-hint field reported in DTMCS bits [14:12].

Ports:
- clock, input, 1: TCK from the TAP. All logic is on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- instruction, input, 5: currently selected JTAG instruction.
- tap_reset, input, 1: TAP Test-Logic-Reset indication.
- dr_shift, input, 1: Shift-DR.
- dr_capture, input, 1: Capture-DR.
- dr_update, input, 1: Update-DR.
- dr_data, input, 1: TDI bit shifted in.
- dr_tdo, output, 1: TDO bit returned to the TAP.
- dmi_req_valid, output, 1; dmi_req_ready, input, 1.
- dmi_req_addr, output, ABITS; dmi_req_data, output, 32; dmi_req_op, output, 2 (1 = read, 2 = write).
- dmi_resp_valid, input, 1; dmi_resp_ready, output, 1.
- dmi_resp_data, input, 32; dmi_resp_resp, input, 2 (0 = OK, anything else = failed).

Behaviour:
- Register lengths: DMI is ABITS+34 bits ({addr, data[31:0], op[1:0]}); DTMCS is 32; IDCODE is 32; BYPASS is 1.
- Shift register: one shared register, width ABITS+34.
  - dr_tdo = sr[0] at all times.
  - While dr_shift is high: sr shifts right each cycle and dr_data is inserted at bit (len-1) of the selected register.
- Capture: when dr_capture is high, load the selected register.
  - DMI: {last_addr, result_data, status}. status = 3 if the FSM is not IDLE, otherwise the sticky value.
  - DTMCS: {14'b0, 2'b0 (dmihardreset, dmireset), 1'b0, DTM_IDLE, dmistat = sticky, ABITS[5:0], 4'd1}.
  - IDCODE: IDCODE. BYPASS: 0.
- Update is edge-qualified: it acts only on the first cycle of dr_update (upd_q registers the previous dr_update).
- DMI update:
  - Ignored if the FSM is not IDLE; in that case sticky is set to 3.
  - Ignored if sticky != 0, or if op is 0 or 3.
  - Otherwise latch addr, data and op into the request registers, set last_addr = addr, and go to REQ on the next edge.
- DTMCS update:
  - Bit 16 (dmireset) clears sticky.
  - Bit 17 (dmihardreset) clears sticky and sets the discard flag if the FSM is not IDLE.
- FSM states are IDLE, REQ and RESP.
  - REQ: dmi_req_valid = 1 with stable payload. Go to RESP when dmi_req_ready = 1.
  - RESP: dmi_resp_ready = 1. When dmi_resp_valid = 1, go to IDLE.
    - If discard is set: clear discard, leave result unchanged.
    - Otherwise: result_data <= resp_data; if resp != 0 then sticky <= 2 (a busy value of 3 takes priority).
- Same-cycle events:
  - If response completion and a DTMCS dmireset coincide, the dmireset wins; sticky ends at 0.
  - A busy event in the same cycle as a failed response yields sticky = 3.
- tap_reset (synchronous to clock): clears sticky, result_data, last_addr and sr.
  - It does not abort REQ or RESP; the handshake completes and its response is discarded (discard <= 1).
- Reset values (reset low): FSM IDLE, all outputs 0, sticky 0, discard 0, sr 0, upd_q 0.
- Latency: the first dr_update cycle is followed by dmi_req_valid at the next edge.

Optional Feature:
- Macro: JTAG_DMI_IDCODE_EN.
- Defined: instruction 0x01 selects the 32-bit IDCODE register.
- Undefined: 0x01 falls through to the 1-bit BYPASS register, and the IDCODE parameter is unused.

Decomposition:
- Package jtag_dmi_pkg holds:
  - Instruction constants IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11.
  - DMI op enum (NOP, READ, WRITE, RSV) and status enum (OK, RSV, FAILED, BUSY).
  - dtmcs_t packed struct.
  - FSM state enum.
- One sub-module, jtag_dmi_req_fsm: the IDLE/REQ/RESP handshake FSM with the discard logic and request payload registers. The top level holds the shift register, capture/update decode and sticky status.

Test Plan:
- Reset low, then select IR 0x10, capture and shift 32 bits -> TDO stream is 32'h0000_1071 LSB first (ABITS = 7, idle = 1, version = 1).
- Select IR 0x11, shift {addr 7'h10, data 32'hDEADBEEF, op 2}, update; dmi_req_ready is high -> one-cycle request with addr 0x10, data 0xDEADBEEF, op 2.
  - Then respond with resp 0, data 0x0. Next capture returns status 0 and addr 0x10.
- Read of 7'h11: respond data 0x12345678, resp 0 -> next DMI capture shifts out {7'h11, 32'h12345678, 2'b00}.
- Hold dmi_req_ready low and capture DMI -> status 3.
  - A following update is ignored (no second request).
  - DTMCS update with bit 16 = 1 clears dmistat to 0.
- Response resp = 2 -> dmistat = 2. Further DMI updates produce no request until dmireset.
- dmihardreset while in RESP, then response data 0xAAAA5555 -> result_data unchanged, FSM returns to IDLE, sticky 0.
- IR 0x01 -> with the macro defined, 32-bit IDCODE is shifted out; with it undefined, a 1-cycle bypass delay (TDO = TDI delayed by one cycle, first bit 0).
